reaction_counter: RTL and testbench

//  Reaction-time measurement stage of the reaction timer: on start, waits a pseudo-random delay,

---
 rtl/reaction_pkg.sv | 16 +
 rtl/bcd_counter.sv | 47 ++++
 rtl/reaction_counter.sv | 123 ++++++++++++
 tb/tb_reaction_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared reaction-timer types: FSM states, LFSR seed/taps and BCD constants.
// Also used by the high_score and display drivers.
package reaction_pkg;

  typedef enum logic [2:0] {IDLE, WAIT, COUNT, DONE, FAULT} state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps 16,14,13,11 in 1-based numbering map to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [3:0]  BCD_NINE  = 4'h9;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// Saturating N-digit BCD incrementer; q updates one cycle after inc, holds at all-9s.
// No backpressure: inc is ignored while sat is high.
module bcd_counter
  import reaction_pkg::*;
#(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*N_DIGITS-1:0] q,
  output logic                  sat
);

  logic [4*N_DIGITS-1:0] q_nxt;
  logic                  carry;

  always_comb begin
    sat = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (q[4*i +: 4] != BCD_NINE) sat = 1'b0;
    end
  end

  // Ripple the carry from the least significant digit upward.
  always_comb begin
    q_nxt = q;
    carry = inc & ~sat;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (carry) begin
        if (q[4*i +: 4] == BCD_NINE) begin
          q_nxt[4*i +: 4] = 4'd0;
        end else begin
          q_nxt[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) q <= '0;
    else              q <= q_nxt;
  end

endmodule

// File: rtl/reaction_counter.sv
// Reaction timer: random WAIT delay, GO LED, BCD ms count until react; outputs registered, no backpressure.
// REACT_FALSE_START_EN adds the FAULT state for react pressed during WAIT.
module reaction_counter
  import reaction_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 50_000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  react,
  output logic                  led_go,
  output logic [4*N_DIGITS-1:0] score,
  output logic                  score_valid,
  output logic                  timeout,
  output logic                  false_start
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(MIN_DELAY_MS + 1024);

  state_t        state;
  logic          start_q, react_q, start_rise, react_rise;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic [DW-1:0] delay_ms;
  logic          tick, enter_wait, bcd_inc, sat;

  assign start_rise = start & ~start_q;
  assign react_rise = react & ~react_q;
  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign bcd_inc    = (state == COUNT) && tick;

  always_comb begin
    enter_wait = start_rise && (state == IDLE || state == DONE);
`ifdef REACT_FALSE_START_EN
    if (start_rise && state == FAULT) enter_wait = 1'b1;
`endif
  end

  bcd_counter #(.N_DIGITS(N_DIGITS)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .clr   (enter_wait),
    .inc   (bcd_inc),
    .q     (score),
    .sat   (sat)
  );

`ifdef REACT_FALSE_START_EN
  logic fs_q;
  assign false_start = fs_q;
`else
  assign false_start = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      led_go      <= 1'b0;
      score_valid <= 1'b0;
      timeout     <= 1'b0;
      presc       <= '0;
      delay_ms    <= '0;
      lfsr        <= LFSR_SEED;
      start_q     <= 1'b0;
      react_q     <= 1'b0;
`ifdef REACT_FALSE_START_EN
      fs_q        <= 1'b0;
`endif
    end else begin
      start_q     <= start;
      react_q     <= react;
      lfsr        <= lfsr_next(lfsr);
      score_valid <= 1'b0;
      if (state == WAIT || state == COUNT) presc <= tick ? '0 : presc + PW'(1);

      if (enter_wait) begin
        state    <= WAIT;
        delay_ms <= DW'(MIN_DELAY_MS) + DW'(lfsr[9:0]);
        presc    <= '0;
        led_go   <= 1'b0;
        timeout  <= 1'b0;
`ifdef REACT_FALSE_START_EN
        fs_q     <= 1'b0;
`endif
      end else begin
        case (state)
          WAIT: begin
`ifdef REACT_FALSE_START_EN
            if (react_rise) begin
              state <= FAULT;
              fs_q  <= 1'b1;
              presc <= '0;
            end else
`endif
            if (delay_ms == '0) begin
              state  <= COUNT;
              led_go <= 1'b1;
              presc  <= '0;
            end else if (tick) begin
              delay_ms <= delay_ms - DW'(1);
            end
          end
          // A tick coinciding with react is still counted by u_bcd this cycle.
          COUNT: begin
            if (react_rise || sat) begin
              state       <= DONE;
              led_go      <= 1'b0;
              score_valid <= 1'b1;
              timeout     <= ~react_rise;
              presc       <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reaction_counter.sv
// Bench for reaction_counter: table-driven react trials scored through a queue, plus reset,
// saturation, start/react collision and false-start sequences.
module tb_reaction_counter;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset, start, react, start2, react2;
  logic        led_go, score_valid, timeout, false_start;
  logic [15:0] score;
  logic        led_go2, score_valid2, timeout2, false_start2;
  logic [7:0]  score2;

  always #5 clk = ~clk;

  reaction_counter #(.N_DIGITS(4), .TICK_DIV(TD), .MIN_DELAY_MS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .react(react),
    .led_go(led_go), .score(score), .score_valid(score_valid),
    .timeout(timeout), .false_start(false_start)
  );

  reaction_counter #(.N_DIGITS(2), .TICK_DIV(TD), .MIN_DELAY_MS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .react(react2),
    .led_go(led_go2), .score(score2), .score_valid(score_valid2),
    .timeout(timeout2), .false_start(false_start2)
  );

  typedef struct { logic [15:0] score; logic timeout; } exp_t;
  typedef struct { int ticks; logic [15:0] exp_score; } vec_t;

  exp_t sbq[$];
  vec_t vecs[6];
  int   checks = 0;
  int   passes = 0;
  int   sv_count = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Scoreboard: every score_valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (score_valid === 1'b1) begin
      sv_count++;
      check("score_valid expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("done score", 32'(score), 32'(e.score));
        check("done timeout", 32'(timeout), 32'(e.timeout));
        check("done led_go", 32'(led_go), 32'd0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_go(input string name, output int waited);
    waited = 0;
    while (led_go !== 1'b1 && waited < 5000) begin
      cyc(1);
      waited++;
    end
    check(name, 32'(led_go), 32'd1);
  endtask

  task automatic react_after(input string name, input int ticks, input logic [15:0] exp_score);
    exp_t e;
    int   n0;
    cyc(TD * ticks + 1);
    check({name, " running score"}, 32'(score), 32'(exp_score));
    e.score   = exp_score;
    e.timeout = 1'b0;
    sbq.push_back(e);
    n0 = sv_count;
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    cyc(2);
    check({name, " enable pulses"}, 32'(sv_count - n0), 32'd1);
    check({name, " score held"}, 32'(score), 32'(exp_score));
    check({name, " led_go off"}, 32'(led_go), 32'd0);
    check({name, " pending"}, 32'(sbq.size()), 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n0;
    vecs[0] = '{37,  16'h0037};
    vecs[1] = '{109, 16'h0109};
    vecs[2] = '{1,   16'h0001};
    vecs[3] = '{10,  16'h0010};
    vecs[4] = '{99,  16'h0099};
    vecs[5] = '{100, 16'h0100};

    reset = 1'b1; start = 1'b0; react = 1'b0; start2 = 1'b0; react2 = 1'b0;
    cyc(3);
    check("reset led_go", 32'(led_go), 32'd0);
    check("reset score", 32'(score), 32'd0);
    check("reset score_valid", 32'(score_valid), 32'd0);
    check("reset timeout", 32'(timeout), 32'd0);
    check("reset false_start", 32'(false_start), 32'd0);
    reset = 1'b0;
    cyc(20);
    check("idle stays dark", 32'(led_go), 32'd0);

    for (int i = 0; i < 6; i++) begin
      pulse_start();
      wait_go("vec go", w);
      check("vec min delay", 32'(w >= 2 * TD), 32'd1);
      react_after("vec", vecs[i].ticks, vecs[i].exp_score);
    end

    // Reset held mid-COUNT.
    pulse_start();
    wait_go("rst go", w);
    cyc(20);
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("midrst led_go", 32'(led_go), 32'd0);
    check("midrst score", 32'(score), 32'd0);
    check("midrst score_valid", 32'(score_valid), 32'd0);
    check("midrst timeout", 32'(timeout), 32'd0);
    check("midrst false_start", 32'(false_start), 32'd0);
    cyc(3 * TD);
    check("midrst idle", 32'(led_go), 32'd0);
    pulse_start();
    wait_go("post rst go", w);
    react_after("post rst", 2, 16'h0002);

    // start and react together in DONE: start wins, new WAIT clears score.
    n0 = sv_count;
    start = 1'b1; react = 1'b1;
    cyc(1);
    start = 1'b0; react = 1'b0;
    cyc(1);
    check("collide score cleared", 32'(score), 32'd0);
    check("collide led_go", 32'(led_go), 32'd0);
    check("collide no enable", 32'(sv_count - n0), 32'd0);
    wait_go("collide go", w);
    react_after("collide", 5, 16'h0005);

    // react during WAIT.
    pulse_start();
    cyc(2);
    react = 1'b1;
    cyc(1);
    react = 1'b0;
    cyc(1);
`ifdef REACT_FALSE_START_EN
    check("fs flag", 32'(false_start), 32'd1);
    check("fs score", 32'(score), 32'd0);
    n0 = sv_count;
    cyc(200);
    check("fs led_go", 32'(led_go), 32'd0);
    check("fs flag held", 32'(false_start), 32'd1);
    check("fs no enable", 32'(sv_count - n0), 32'd0);
    pulse_start();
    check("fs cleared", 32'(false_start), 32'd0);
    wait_go("fs retry go", w);
    react_after("fs retry", 3, 16'h0003);
`else
    check("early react ignored", 32'(false_start), 32'd0);
    wait_go("early react go", w);
    react_after("early react", 3, 16'h0003);
`endif

    // Two-digit instance saturates without react.
    start2 = 1'b1;
    cyc(1);
    start2 = 1'b0;
    w = 0;
    while (led_go2 !== 1'b1 && w < 5000) begin
      cyc(1);
      w++;
    end
    check("sat go", 32'(led_go2), 32'd1);
    w = 0;
    while (score_valid2 !== 1'b1 && w < 600) begin
      cyc(1);
      w++;
    end
    check("sat score_valid", 32'(score_valid2), 32'd1);
    check("sat score", 32'(score2), 32'h99);
    check("sat timeout", 32'(timeout2), 32'd1);
    check("sat led_go", 32'(led_go2), 32'd0);
    cyc(1);
    check("sat pulse width", 32'(score_valid2), 32'd0);
    check("sat timeout held", 32'(timeout2), 32'd1);
    check("sat score held", 32'(score2), 32'h99);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
